// File: rtl/core_avl_arbiter_2to1_if.sv
// Avalon-MM command/response bundle shared by the arbiter's master and slave sides.
// A command transfers on a cycle where (read || write) && request_ready; a read beat
// transfers on any cycle with read_data_valid (no back-pressure on responses).
interface core_avl_arbiter_2to1_if #(
  parameter int BURST_W = 8
);
  logic [31:0]        address;
  logic               read;
  logic               write;
  logic [3:0]         byte_en;
  logic [31:0]        write_data;
  logic               begin_burst_transfer;
  logic [BURST_W-1:0] burst_count;
  logic               request_ready;
  logic [31:0]        read_data;
  logic               read_data_valid;

  modport master (
    output address, read, write, byte_en, write_data, begin_burst_transfer, burst_count,
    input  request_ready, read_data, read_data_valid
  );

  modport slave (
    input  address, read, write, byte_en, write_data, begin_burst_transfer, burst_count,
    output request_ready, read_data, read_data_valid
  );
endinterface

// File: rtl/core_avl_arbiter_2to1.sv
// Round-robin 2:1 Avalon-MM arbiter with grant hold, write-burst lock and an
// ID FIFO that routes returning read beats to the master that issued the read.
module core_avl_arbiter_2to1 #(
  parameter int OUTSTANDING_DEPTH = 4,
  parameter int BURST_W           = 8
) (
  input  logic                  clk,
  input  logic                  rest,
  core_avl_arbiter_2to1_if.slave  avl_m0,
  core_avl_arbiter_2to1_if.slave  avl_m1,
  core_avl_arbiter_2to1_if.master avl_s0,
  output logic                  err_unexpected_rsp
);
  localparam int PTR_W = $clog2(OUTSTANDING_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(OUTSTANDING_DEPTH);

  logic               last_grant;
  logic               hold_valid, hold_id;
  logic               lock_valid, lock_id;
  logic [BURST_W-1:0] wbeats, rbeats;

  logic               fifo_id    [OUTSTANDING_DEPTH];
  logic [BURST_W-1:0] fifo_beats [OUTSTANDING_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;

  logic               fifo_full, fifo_empty;
  logic               elig0, elig1;
  logic               grant_valid, grant_id;
  logic               accept, push, pop, rsp_hit;
  logic [BURST_W-1:0] eff_count, rbeats_nxt;

  logic [31:0]        cmd_address, cmd_write_data;
  logic               cmd_read, cmd_write, cmd_begin;
  logic [3:0]         cmd_byte_en;
  logic [BURST_W-1:0] cmd_burst_count;

  assign fifo_full  = (count >= DEPTH_CNT);
  assign fifo_empty = (count == '0);

  // The full test ignores a same-cycle pop so the eligibility path stays short.
  assign elig0 = avl_m0.write || (avl_m0.read && !fifo_full);
  assign elig1 = avl_m1.write || (avl_m1.read && !fifo_full);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (lock_valid) begin
      grant_valid = 1'b1;
      grant_id    = lock_id;
    end else if (hold_valid) begin
      grant_valid = 1'b1;
      grant_id    = hold_id;
    end else if (elig0 && elig1) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (elig0) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (elig1) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  always_comb begin
    cmd_address     = '0;
    cmd_read        = 1'b0;
    cmd_write       = 1'b0;
    cmd_byte_en     = '0;
    cmd_write_data  = '0;
    cmd_begin       = 1'b0;
    cmd_burst_count = '0;
    if (grant_valid && !grant_id) begin
      cmd_address     = avl_m0.address;
      cmd_read        = avl_m0.read;
      cmd_write       = avl_m0.write;
      cmd_byte_en     = avl_m0.byte_en;
      cmd_write_data  = avl_m0.write_data;
      cmd_begin       = avl_m0.begin_burst_transfer;
      cmd_burst_count = avl_m0.burst_count;
    end else if (grant_valid && grant_id) begin
      cmd_address     = avl_m1.address;
      cmd_read        = avl_m1.read;
      cmd_write       = avl_m1.write;
      cmd_byte_en     = avl_m1.byte_en;
      cmd_write_data  = avl_m1.write_data;
      cmd_begin       = avl_m1.begin_burst_transfer;
      cmd_burst_count = avl_m1.burst_count;
    end
  end

  assign avl_s0.address              = cmd_address;
  assign avl_s0.read                 = cmd_read;
  assign avl_s0.write                = cmd_write;
  assign avl_s0.byte_en              = cmd_byte_en;
  assign avl_s0.write_data           = cmd_write_data;
  assign avl_s0.begin_burst_transfer = cmd_begin;
  assign avl_s0.burst_count          = cmd_burst_count;

  assign avl_m0.request_ready = grant_valid && !grant_id && avl_s0.request_ready;
  assign avl_m1.request_ready = grant_valid &&  grant_id && avl_s0.request_ready;

  assign accept     = (cmd_read || cmd_write) && avl_s0.request_ready;
  assign push       = accept && cmd_read;
  assign eff_count  = (cmd_burst_count == '0) ? BURST_W'(1) : cmd_burst_count;

  // Read beats are routed by the oldest outstanding read; data is broadcast.
  assign rsp_hit    = avl_s0.read_data_valid && !fifo_empty;
  assign rbeats_nxt = rbeats + BURST_W'(1);
  assign pop        = rsp_hit && (rbeats_nxt == fifo_beats[rd_ptr]);

  assign avl_m0.read_data       = avl_s0.read_data;
  assign avl_m1.read_data       = avl_s0.read_data;
  assign avl_m0.read_data_valid = rsp_hit && !fifo_id[rd_ptr];
  assign avl_m1.read_data_valid = rsp_hit &&  fifo_id[rd_ptr];

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      last_grant         <= 1'b1;
      hold_valid         <= 1'b0;
      hold_id            <= 1'b0;
      lock_valid         <= 1'b0;
      lock_id            <= 1'b0;
      wbeats             <= '0;
      rbeats             <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        hold_valid <= 1'b0;
      end else if (grant_valid) begin
        hold_valid <= 1'b1;
        hold_id    <= grant_id;
      end

      if (accept && cmd_write) begin
        if (!lock_valid) begin
          if (eff_count > BURST_W'(1)) begin
            lock_valid <= 1'b1;
            lock_id    <= grant_id;
            wbeats     <= eff_count - BURST_W'(1);
          end
        end else begin
          wbeats <= wbeats - BURST_W'(1);
          if (wbeats == BURST_W'(1)) lock_valid <= 1'b0;
        end
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase

      if (rsp_hit) rbeats <= pop ? '0 : rbeats_nxt;
      if (avl_s0.read_data_valid && fifo_empty) err_unexpected_rsp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]    <= grant_id;
      fifo_beats[wr_ptr] <= eff_count;
    end
  end
endmodule

// File: tb/tb_core_avl_arbiter_2to1.sv
// Bench for core_avl_arbiter_2to1: directed scenarios plus random masters/slave,
// all outputs compared each cycle against a queue-based transaction model.
module tb_core_avl_arbiter_2to1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rest;
  logic err_unexpected_rsp;
  always #5 clk = ~clk;

  core_avl_arbiter_2to1_if #(.BURST_W(8)) avl_m0 ();
  core_avl_arbiter_2to1_if #(.BURST_W(8)) avl_m1 ();
  core_avl_arbiter_2to1_if #(.BURST_W(8)) avl_s0 ();

  core_avl_arbiter_2to1 #(.OUTSTANDING_DEPTH(DEPTH), .BURST_W(8)) dut (
    .clk(clk), .rest(rest), .avl_m0(avl_m0), .avl_m1(avl_m1), .avl_s0(avl_s0),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  // Master and slave stimulus
  logic        m_rd [2], m_wr [2], m_bb [2];
  logic [31:0] m_addr [2], m_wd [2];
  logic [3:0]  m_be [2];
  logic [7:0]  m_bc [2];
  logic        s_ready, s_rdv;
  logic [31:0] s_rdata;

  assign avl_m0.address = m_addr[0];  assign avl_m1.address = m_addr[1];
  assign avl_m0.read    = m_rd[0];    assign avl_m1.read    = m_rd[1];
  assign avl_m0.write   = m_wr[0];    assign avl_m1.write   = m_wr[1];
  assign avl_m0.byte_en = m_be[0];    assign avl_m1.byte_en = m_be[1];
  assign avl_m0.write_data = m_wd[0]; assign avl_m1.write_data = m_wd[1];
  assign avl_m0.begin_burst_transfer = m_bb[0];
  assign avl_m1.begin_burst_transfer = m_bb[1];
  assign avl_m0.burst_count = m_bc[0]; assign avl_m1.burst_count = m_bc[1];
  assign avl_s0.request_ready   = s_ready;
  assign avl_s0.read_data       = s_rdata;
  assign avl_s0.read_data_valid = s_rdv;

  // Scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: owner = master that must keep the bus (waiting or mid write burst)
  typedef struct { bit id; int beats; } rd_t;
  rd_t rd_q[$];
  int  own;
  int  burst_left;
  bit  last_g;
  bit  err_m;
  logic [1:0] last_rdy;

  task automatic model_reset();
    own = -1; burst_left = 0; last_g = 1'b1; err_m = 1'b0;
    rd_q.delete();
  endtask

  // Evaluate one clock: inputs were set at the preceding negedge.
  task automatic cycle();
    bit e0, e1, gv, acc;
    int g, eff;
    logic [14:0] cmd_exp;
    logic [31:0] addr_exp, wd_exp;
    logic [1:0]  rdy_exp, rdv_exp;
    #1;
    if (rest) model_reset();
    e0 = m_wr[0] || (m_rd[0] && rd_q.size() < DEPTH);
    e1 = m_wr[1] || (m_rd[1] && rd_q.size() < DEPTH);
    gv = 1'b1; g = 0;
    if (own >= 0)       g = own;
    else if (e0 && e1)  g = last_g ? 0 : 1;
    else if (e0)        g = 0;
    else if (e1)        g = 1;
    else                gv = 1'b0;
    cmd_exp  = gv ? {m_rd[g], m_wr[g], m_be[g], m_bb[g], m_bc[g]} : '0;
    addr_exp = gv ? m_addr[g] : '0;
    wd_exp   = gv ? m_wd[g] : '0;
    rdy_exp  = '0;
    if (gv) rdy_exp[g] = s_ready;
    rdv_exp  = '0;
    if (s_rdv && rd_q.size() > 0) rdv_exp[rd_q[0].id] = 1'b1;

    check("s0_cmd", {avl_s0.read, avl_s0.write, avl_s0.byte_en,
                     avl_s0.begin_burst_transfer, avl_s0.burst_count}, cmd_exp);
    check("s0_address", avl_s0.address, addr_exp);
    check("s0_write_data", avl_s0.write_data, wd_exp);
    check("request_ready", {avl_m1.request_ready, avl_m0.request_ready}, rdy_exp);
    check("read_data_valid", {avl_m1.read_data_valid, avl_m0.read_data_valid}, rdv_exp);
    check("read_data", {avl_m1.read_data, avl_m0.read_data}, {s_rdata, s_rdata});
    check("err_unexpected_rsp", err_unexpected_rsp, err_m);
    last_rdy = {avl_m1.request_ready, avl_m0.request_ready};

    if (!rest) begin
      if (s_rdv) begin
        if (rd_q.size() == 0) err_m = 1'b1;
        else begin
          rd_q[0].beats--;
          if (rd_q[0].beats == 0) void'(rd_q.pop_front());
        end
      end
      acc = gv && (m_rd[g] || m_wr[g]) && s_ready;
      if (acc) begin
        last_g = g[0];
        eff = (m_bc[g] == 0) ? 1 : int'(m_bc[g]);
        if (m_wr[g]) begin
          if (burst_left == 0) begin
            if (eff > 1) burst_left = eff - 1;
          end else burst_left--;
        end
        if (m_rd[g]) rd_q.push_back('{id: g[0], beats: eff});
        own = (burst_left > 0) ? g : -1;
      end else if (gv) own = g;
    end
    @(negedge clk);
  endtask

  task automatic idle_master(input int i);
    m_rd[i] = 0; m_wr[i] = 0; m_bb[i] = 0; m_bc[i] = 0;
    m_addr[i] = 0; m_wd[i] = 0; m_be[i] = 0;
  endtask

  task automatic drive(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [7:0] bc, input bit bb);
    m_rd[i] = rd; m_wr[i] = wr; m_addr[i] = addr; m_bc[i] = bc; m_bb[i] = bb;
    m_be[i] = 4'hf; m_wd[i] = $urandom;
  endtask

  task automatic apply_reset();
    idle_master(0); idle_master(1);
    s_ready = 0; s_rdv = 0; s_rdata = 0;
    rest = 1'b1;
    cycle(); cycle();
    rest = 1'b0;
  endtask

  // Random masters hold each command until accepted; write bursts issue one beat per accept.
  bit busy [2];
  int left [2];

  task automatic agents();
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && last_rdy[i]) begin
        if (m_wr[i] && left[i] > 1) begin
          left[i]--; m_bb[i] = 0; m_wd[i] = $urandom; m_be[i] = 4'($urandom_range(1, 15));
        end else begin
          busy[i] = 0; idle_master(i);
        end
      end
      if (!busy[i] && $urandom_range(0, 9) < 4) begin
        busy[i] = 1; m_bb[i] = 1;
        m_addr[i] = $urandom & 32'hffff_fffc;
        m_be[i] = 4'($urandom_range(1, 15)); m_wd[i] = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          m_rd[i] = 1; m_wr[i] = 0; m_bc[i] = 8'($urandom_range(0, 3)); left[i] = 1;
        end else begin
          m_rd[i] = 0; m_wr[i] = 1; m_bc[i] = 8'($urandom_range(0, 4));
          left[i] = (m_bc[i] == 0) ? 1 : int'(m_bc[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    last_rdy = '0;
    idle_master(0); idle_master(1);
    s_ready = 0; s_rdv = 0; s_rdata = 0; rest = 1'b1;
    @(negedge clk);
    apply_reset();

    // Single m0 read, one response beat
    s_ready = 1; drive(0, 1, 0, 32'h100, 8'd1, 1);
    #1;
    check("t1_s0_address", avl_s0.address, 32'h100);
    check("t1_m0_ready", avl_m0.request_ready, 1'b1);
    cycle(); idle_master(0); cycle();
    s_rdv = 1; s_rdata = 32'hdeadbeef;
    #1;
    check("t1_rdv", {avl_m1.read_data_valid, avl_m0.read_data_valid}, 2'b01);
    cycle(); s_rdv = 0; cycle();

    // Simultaneous reads after reset: m0 first, in-order responses
    apply_reset();
    s_ready = 1; drive(0, 1, 0, 32'ha0, 8'd1, 1); drive(1, 1, 0, 32'hb0, 8'd1, 1);
    cycle(); idle_master(0); cycle(); idle_master(1);
    s_rdv = 1; s_rdata = 32'haaaa_0000; cycle();
    s_rdata = 32'hbbbb_0000;
    #1;
    check("t2_rdv_b", {avl_m1.read_data_valid, avl_m0.read_data_valid}, 2'b10);
    cycle(); s_rdv = 0; cycle();

    // Hold: m1 write waits 3 cycles, m0 read arrives in cycle 2
    apply_reset();
    s_ready = 0; drive(1, 0, 1, 32'h40, 8'd1, 1);
    cycle(); drive(0, 1, 0, 32'h80, 8'd1, 1);
    cycle(); cycle();
    s_ready = 1;
    #1;
    check("t3_m1_accept", {avl_m1.request_ready, avl_m0.request_ready}, 2'b10);
    cycle(); idle_master(1); cycle(); idle_master(0); cycle();

    // Write burst lock: m1 read waits for all four m0 beats
    apply_reset();
    s_ready = 1; drive(0, 0, 1, 32'h200, 8'd4, 1); drive(1, 1, 0, 32'h300, 8'd1, 1);
    cycle(); m_bb[0] = 0;
    for (int b = 0; b < 3; b++) begin m_wd[0] = $urandom; cycle(); end
    idle_master(0);
    #1;
    check("t4_m1_after_burst", avl_m1.request_ready, 1'b1);
    cycle(); idle_master(1); cycle();

    // Outstanding limit: 5th read blocked until a response frees a slot
    apply_reset();
    s_ready = 1;
    for (int k = 0; k < 4; k++) begin drive(1, 1, 0, 32'h1000 + 32'(k * 4), 8'd1, 1); cycle(); end
    drive(1, 1, 0, 32'h1010, 8'd1, 1); drive(0, 0, 1, 32'h20, 8'd1, 1);
    #1;
    check("t5_m1_blocked", avl_m1.request_ready, 1'b0);
    check("t5_m0_write", avl_m0.request_ready, 1'b1);
    cycle(); idle_master(0);
    s_rdv = 1; cycle(); s_rdv = 0;
    #1;
    check("t5_m1_accept", avl_m1.request_ready, 1'b1);
    cycle(); idle_master(1); cycle();

    // Stray response, sticky error, reset during a locked burst
    apply_reset();
    s_rdv = 1; cycle(); s_rdv = 0; cycle(); cycle();
    check("t6_err_sticky", err_unexpected_rsp, 1'b1);
    s_ready = 1; drive(0, 0, 1, 32'h500, 8'd4, 1);
    cycle(); m_bb[0] = 0; cycle();
    idle_master(0); rest = 1'b1;
    #1;
    check("t6_s0_idle", {avl_s0.read, avl_s0.write, avl_s0.address}, '0);
    check("t6_err_cleared", err_unexpected_rsp, 1'b0);
    cycle();
    drive(1, 1, 0, 32'h600, 8'd1, 1); cycle();
    rest = 1'b0; idle_master(1); cycle();
    s_rdv = 1; cycle(); s_rdv = 0; cycle();

    // Random traffic against the model
    apply_reset();
    busy[0] = 0; busy[1] = 0; last_rdy = '0;
    for (int c = 0; c < 3000; c++) begin
      agents();
      s_ready = ($urandom_range(0, 3) != 0);
      s_rdv   = (rd_q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/core_avl_arbiter_2to1.md
Name: core_avl_arbiter_2to1

Overview:
Two-master to one-slave Avalon-MM arbiter for the core's single memory port. Master m0 is instruction fetch; master m1 is the MA-stage LSU address generator. The LSU can split a misaligned access into two single-beat commands.
The block arbitrates commands round-robin and holds a grant until the presented command is accepted. It locks for write bursts and tracks outstanding reads in an ID FIFO, so returning read data is routed to the master that issued the read.

Parameters:
OUTSTANDING_DEPTH, 4, max read commands in flight (power of 2, >=2)
BURST_W, 8, width of burst_count fields

Ports:
clk  in  1  core clock
rest  in  1  asynchronous reset, active-high
avl_m0_address / avl_m1_address  in  32  master command address
avl_m0_read / avl_m1_read  in  1  read request
avl_m0_write / avl_m1_write  in  1  write request
avl_m0_byte_en / avl_m1_byte_en  in  4  byte enables
avl_m0_write_data / avl_m1_write_data  in  32  write data
avl_m0_begin_burst_transfer / avl_m1_begin_burst_transfer  in  1  burst start marker
avl_m0_burst_count / avl_m1_burst_count  in  BURST_W  beats (0 treated as 1)
avl_m0_request_ready / avl_m1_request_ready  out  1  command accepted this cycle
avl_m0_read_data / avl_m1_read_data  out  32  read data (broadcast copy of slave data)
avl_m0_read_data_valid / avl_m1_read_data_valid  out  1  read beat belongs to this master
avl_s0_address, avl_s0_read, avl_s0_write, avl_s0_byte_en, avl_s0_write_data, avl_s0_begin_burst_transfer, avl_s0_burst_count  out  as master side  muxed command to slave
avl_s0_request_ready  in  1  slave accepts command
avl_s0_read_data  in  32  slave read data
avl_s0_read_data_valid  in  1  slave read beat valid
err_unexpected_rsp  out  1  sticky: read beat arrived with no outstanding read

Behaviour:
- Reset (rest=1, async): last_grant=1, hold_valid=0, lock_valid=0, beat counters=0, FIFO empty, err_unexpected_rsp=0. All s0 command outputs are 0 and both request_ready=0 while no master requests.
- req_i = read_i||write_i. A read request from master i is eligible only if FIFO count < OUTSTANDING_DEPTH. The full check does not account for a pop in the same cycle. Writes are always eligible.
- Grant selection is combinational, with zero-cycle latency from request to s0, in priority order:
  1. lock_valid: grant lock_id.
  2. hold_valid: grant hold_id.
  3. Exactly one eligible requester: grant it.
  4. Both eligible: grant !last_grant.
  5. Otherwise: no grant; all s0 command outputs are 0.
- s0 command outputs mirror the granted master. avl_mi_request_ready = granted_i && avl_s0_request_ready. The non-granted master sees request_ready=0.
- accept = s0 read||write && avl_s0_request_ready.
- Hold: if a grant is given and not accepted, set hold_valid=1 and hold_id=grant for the next cycle. This prevents grant switching while a master waits. Clear hold on accept.
- On accept, last_grant <= grant.
- Write burst lock: on an accepted write with eff_count=max(burst_count,1) > 1 and lock_valid=0, set lock_valid=1, lock_id=grant, wbeats=eff_count-1. Each later accepted write beat decrements wbeats. Clear the lock when the beat accepted with wbeats==1 is taken.
- Read tracking: on an accepted read, push {id=grant, beats=eff_count} into the FIFO. The read command is a single cycle even for a burst.
- Response routing: head = FIFO head. On avl_s0_read_data_valid with the FIFO non-empty:
  - assert avl_m{head.id}_read_data_valid in the same cycle (combinational);
  - rbeats counts beats received for the head entry; pop when rbeats+1 == head.beats, and reset rbeats to 0.
- Response with FIFO empty: no master valid is asserted; set err_unexpected_rsp=1 (cleared only by reset).
- Push and pop in the same cycle: both happen and count is unchanged. The FIFO pointers wrap modulo OUTSTANDING_DEPTH.
- Reset mid-operation discards locks, holds and outstanding reads. Stray responses after reset set the error flag.

Test Plan:
- m0 read @0x100 alone, s0 ready=1 → same-cycle s0_address=0x100, m0_request_ready=1; later one response beat 0xDEADBEEF → m0_read_data_valid=1, m1 valid=0.
- m0, m1 read simultaneously after reset (last_grant=1), ready=1 for 2 cycles → m0 granted cycle 1, m1 cycle 2; in-order responses A, B → A to m0, B to m1.
- m1 write held with s0 ready=0 for 3 cycles while m0 asserts read in cycle 2 → s0 stays on m1 (hold); m1 accepted cycle 4; m0 granted cycle 5.
- m0 write burst_count=4, m1 read pending → m1 not granted until 4th m0 beat accepted; then m1 granted next cycle.
- Issue 4 m1 reads (DEPTH=4) with no responses → 5th read sees request_ready=0; m0 write still accepted. One response → 5th read accepted the next cycle.
- s0_read_data_valid pulse with no reads outstanding → no master valid, err_unexpected_rsp=1 and sticky; assert rest mid-burst → lock cleared, s0 outputs 0 in the same cycle.
